// File: rtl/adder3_share_sequencer_if.sv
// Requester-side bus of the shared three-operand adder sequencer.
// master = requesting datapath, slave = sequencer.
interface adder3_share_sequencer_if #(
  parameter int reg_size = 4
);
  logic [1:0]          req;
  logic [reg_size-1:0] a0, b0, c0;
  logic                cin0;
  logic [reg_size-1:0] a1, b1, c1;
  logic                cin1;
  logic [1:0]          gnt;
  logic                busy;
  logic                done;
  logic                done_id;
  logic [reg_size-1:0] sum;
  logic                cout;

  modport master (
    output req, a0, b0, c0, cin0, a1, b1, c1, cin1,
    input  gnt, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req, a0, b0, c0, cin0, a1, b1, c1, cin1,
    output gnt, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/adder3_share_sequencer.sv
// Two requesters share one ripple adder. Each op runs two passes:
//   pass 1: {c_mid, s_mid} = a + b + cin
//   pass 2: {cout,  sum}   = s_mid + c + c_mid
// which reproduces the cascaded two-adder result. Round-robin arbitration
// happens only in IDLE; one op occupies the adder for 3 cycles.

// One bit of the shared ripple adder.
module adder3_share_sequencer_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder3_share_sequencer #(
  parameter int reg_size = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adder3_share_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, S1 = 2'd1, S2 = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                last_id_q, last_id_d;
  logic                win_q, win_d;
  logic [reg_size-1:0] op_a_q, op_a_d;
  logic [reg_size-1:0] op_b_q, op_b_d;
  logic [reg_size-1:0] op_c_q, op_c_d;
  logic                op_cin_q, op_cin_d;
  logic [reg_size-1:0] s_mid_q, s_mid_d;
  logic                c_mid_q, c_mid_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                done_id_q, done_id_d;
  logic [reg_size-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;

  // Shared adder operands and result
  logic [reg_size-1:0] add_x, add_y, add_s;
  logic                add_ci;
  logic [reg_size:0]   cy;

  logic                nxt_win;

  // Operand mux: pass 1 uses a/b/cin, pass 2 reuses the adder for s_mid/c/c_mid
  always_comb begin
    add_x  = op_a_q;
    add_y  = op_b_q;
    add_ci = op_cin_q;
    if (state_q == S2) begin
      add_x  = s_mid_q;
      add_y  = op_c_q;
      add_ci = c_mid_q;
    end
  end

  assign cy[0] = add_ci;

  genvar g;
  generate
    for (g = 0; g < reg_size; g++) begin : g_bit
      adder3_share_sequencer_fa u_fa (
        .a  (add_x[g]),
        .b  (add_y[g]),
        .ci (cy[g]),
        .s  (add_s[g]),
        .co (cy[g+1])
      );
    end
  endgenerate

  // Round-robin pick: lone requester wins, on contention the one not served last
  assign nxt_win = (bus.req == 2'b11) ? ~last_id_q : bus.req[1];

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    win_d     = win_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_c_d    = op_c_q;
    op_cin_d  = op_cin_q;
    s_mid_d   = s_mid_q;
    c_mid_d   = c_mid_q;
    gnt_d     = 2'b00;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d     = nxt_win;
          last_id_d = nxt_win;
          op_a_d    = nxt_win ? bus.a1   : bus.a0;
          op_b_d    = nxt_win ? bus.b1   : bus.b0;
          op_c_d    = nxt_win ? bus.c1   : bus.c0;
          op_cin_d  = nxt_win ? bus.cin1 : bus.cin0;
          gnt_d     = nxt_win ? 2'b10 : 2'b01;
          busy_d    = 1'b1;
          state_d   = S1;
        end
      end
      S1: begin
        s_mid_d = add_s;
        c_mid_d = cy[reg_size];
        state_d = S2;
      end
      S2: begin
        sum_d     = add_s;
        cout_d    = cy[reg_size];
        done_d    = 1'b1;
        done_id_d = win_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_id_q <= 1'b1;
      win_q     <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_c_q    <= '0;
      op_cin_q  <= 1'b0;
      s_mid_q   <= '0;
      c_mid_q   <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      win_q     <= win_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_c_q    <= op_c_d;
      op_cin_q  <= op_cin_d;
      s_mid_q   <= s_mid_d;
      c_mid_q   <= c_mid_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_adder3_share_sequencer.sv
// Directed bench for the shared three-operand adder sequencer.
module tb_adder3_share_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  adder3_share_sequencer_if #(.reg_size(4)) bus ();

  adder3_share_sequencer #(.reg_size(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".gnt"},  32'(bus.gnt),  32'h0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'h0);
    chk({tag, ".done"}, 32'(bus.done), 32'h0);
    chk({tag, ".sum"},  32'(bus.sum),  32'h0);
    chk({tag, ".cout"}, 32'(bus.cout), 32'h0);
  endtask

  // Run one op from the grant edge to done. req is left as the caller set it
  // unless drop_req, in which case it is released once the grant is seen.
  task automatic run_op(input string tag, input logic [1:0] e_gnt, input logic [3:0] e_sum,
                        input logic e_cout, input logic e_id, input bit drop_req,
                        input bit zap_a0);
    tick();
    chk({tag, ".gnt"},  32'(bus.gnt),  32'(e_gnt));
    chk({tag, ".busy"}, 32'(bus.busy), 32'h1);
    if (drop_req) bus.req = 2'b00;
    if (zap_a0)   bus.a0  = 4'h0;
    tick();
    chk({tag, ".gnt_clr"}, 32'(bus.gnt),  32'h0);
    chk({tag, ".done_lo"}, 32'(bus.done), 32'h0);
    tick();
    chk({tag, ".done"},    32'(bus.done),    32'h1);
    chk({tag, ".sum"},     32'(bus.sum),     32'(e_sum));
    chk({tag, ".cout"},    32'(bus.cout),    32'(e_cout));
    chk({tag, ".done_id"}, 32'(bus.done_id), 32'(e_id));
    chk({tag, ".busy_lo"}, 32'(bus.busy),    32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.a0 = 4'h0; bus.b0 = 4'h0; bus.c0 = 4'h0; bus.cin0 = 1'b0;
    bus.a1 = 4'h0; bus.b1 = 4'h0; bus.c1 = 4'h0; bus.cin1 = 1'b0;

    // 1: reset then idle
    do_reset();
    chk_idle_outs("rst");
    tick();
    tick();
    chk_idle_outs("idle");

    // 2: single request from requester 0: 3+4+0=7, 7+5=C
    bus.a0 = 4'h3; bus.b0 = 4'h4; bus.c0 = 4'h5; bus.cin0 = 1'b0;
    bus.req = 2'b01;
    run_op("single", 2'b01, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("single.done_clr", 32'(bus.done), 32'h0);
    chk("single.sum_hold", 32'(bus.sum),  32'hC);

    // 3: overflow through both passes: F+F+1=1F, F+F+1=1F
    bus.a1 = 4'hF; bus.b1 = 4'hF; bus.c1 = 4'hF; bus.cin1 = 1'b1;
    bus.req = 2'b10;
    run_op("ovf", 2'b10, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ovf.cout_hold", 32'(bus.cout), 32'h1);

    // 4: both request right after reset; requester 0 first
    do_reset();
    bus.a0 = 4'h1; bus.b0 = 4'h1; bus.c0 = 4'h1; bus.cin0 = 1'b0;
    bus.a1 = 4'h2; bus.b1 = 4'h2; bus.c1 = 4'h2; bus.cin1 = 1'b1;
    bus.req = 2'b11;
    run_op("sim0", 2'b01, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sim1", 2'b10, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: continuous contention; a0 cleared after its grant must not affect op
    run_op("cont0", 2'b01, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("cont1", 2'b10, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    // new a0=0 now latched: 0+1+0=1, 1+1=2
    run_op("cont2", 2'b01, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset while in S1
    bus.req = 2'b00;
    tick();
    bus.req = 2'b10;
    tick();
    chk("mid.gnt", 32'(bus.gnt), 32'h2);
    bus.req = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("mid.gnt0",  32'(bus.gnt),  32'h0);
    chk("mid.busy0", 32'(bus.busy), 32'h0);
    chk("mid.sum0",  32'(bus.sum),  32'h0);
    tick();
    tick();
    chk("mid.done0", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    bus.req = 2'b11;
    run_op("post", 2'b01, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adder3_share_sequencer.md
Name: adder3_share_sequencer

Overview:
Shares one reg_size-bit ripple adder between two requesters. Each requester supplies operands a, b, c and a carry-in. The block computes the same two-stage result as the team's cascaded full_adder_nbit pair, in two sequenced passes through a single adder instead of two adder instances. Round-robin arbitration with a req/gnt handshake and a one-cycle done strobe; it sits between requesting datapaths and the shared adder resource.

Parameters:
reg_size, 4, operand/sum width in bits

Ports:
clk  input  1  rising-edge clock, only clock
rst_n  input  1  asynchronous active-low reset
req  input  2  per-requester request; bit i = requester i
a0  input  reg_size  requester 0 operand a
b0  input  reg_size  requester 0 operand b
c0  input  reg_size  requester 0 operand c
cin0  input  1  requester 0 carry-in
a1  input  reg_size  requester 1 operand a
b1  input  reg_size  requester 1 operand b
c1  input  reg_size  requester 1 operand c
cin1  input  1  requester 1 carry-in
gnt  output  2  one-hot grant pulse, one cycle
busy  output  1  high while an operation is in flight (states S1/S2)
done  output  1  one-cycle result-valid strobe
done_id  output  1  requester index that owns the current result
sum  output  reg_size  final sum
cout  output  1  final carry-out

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE and clears gnt, busy, done, done_id, sum, cout and internal stage regs to 0. The RR pointer last_id is set to 1, so requester 0 wins first.
- FSM states: IDLE, S1, S2. All outputs are registered.
- IDLE, no req: stay in IDLE.
- IDLE, any req bit high: at the clock edge,
  - pick the winner: the single requester if only one asks; if both ask, the requester != last_id;
  - latch the winner's a, b, c, cin into operand regs;
  - gnt <= onehot(winner), last_id <= winner, busy <= 1, state <= S1.
- S1: {c_mid, s_mid} <= a + b + cin, using the shared adder, zero-extended to reg_size+1. Then gnt <= 0, state <= S2.
- S2: {cout, sum} <= s_mid + c + c_mid on the same adder. Then done <= 1, done_id <= winner, busy <= 0, state <= IDLE.
- done: cleared on the next edge.
- Result semantics match the two-adder cascade exactly:
  - c_mid feeds stage 2 as its carry-in;
  - c_mid itself is not output;
  - cout is the stage-2 carry only.
- Latency: request sampled at edge 0, gnt visible after edge 0, done/sum valid after edge 2.
- Throughput: a new grant may issue at the same edge that clears done. Maximum rate is one op per 3 cycles.
- sum/cout: hold their value until the next done; they are not cleared when done drops.
- Handshake:
  - a requester holds req and operands stable until it sees gnt;
  - after gnt, operands may change freely, because they are already latched;
  - req still high in IDLE after gnt is treated as a new request.
- req changes while busy: ignored and not queued; arbitration occurs only in IDLE.
- Simultaneous req from both in consecutive IDLE windows: grants alternate strictly.
- Reset mid-operation (S1 or S2): operation aborted, no done pulse, outputs 0. The pointer returns to its reset value.

Test Plan:
1. Hold rst_n=0 for 2 cycles, then release with req=00 -> gnt=00, busy=0, done=0, sum=0, cout=0, state stays IDLE.
2. Single request: req=01, a0=3, b0=4, c0=5, cin0=0 -> gnt=01 one cycle after edge 0; done=1 after edge 2 with sum=4'hC, cout=0, done_id=0.
3. Overflow path: req=10, a1=F, b1=F, c1=F, cin1=1 -> s_mid=F, c_mid=1; result sum=F, cout=1, done_id=1.
4. Simultaneous first request: req=11 right after reset, a0=1,b0=1,c0=1,cin0=0 and a1=2,b1=2,c1=2,cin1=1 -> first done_id=0 with sum=3; next done_id=1 with sum=7; each op takes 3 cycles.
5. Continuous contention: req held at 11 for 12 cycles -> gnt sequence 01,10,01,10 at 3-cycle spacing.
   - Also change a0 to 0 in the cycle after gnt=01 -> that op's result is unaffected.
6. Reset mid-op: assert rst_n=0 while in S1 -> no done, all outputs 0. After release, req=11 -> requester 0 is granted first.
